pulse_peak_detector: RTL and testbench

Downstream consumer of the Bessel-filtered ADC stream (`adc_filt_a`). It detects threshold-crossing pulses, tracks each pulse's maximum, and timestamps it. Each pulse is emitted as one AXI-Stream word to the data splitter / DMA path. Pulses that are too long are rejected as pile-up, and emissions that back-pressure cannot accept are dropped. Both events are counted for software.

---
 rtl/pulse_peak_detector.sv | 100 ++++++++++
 tb/tb_pulse_peak_detector.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/pulse_peak_detector.sv
// pulse_peak_detector: threshold-triggered pulse peak/timestamp capture with pile-up
// rejection, holdoff dead time and a single-entry AXI-Stream output register.
module pulse_peak_detector #(
  parameter int ADC_WIDTH        = 14,
  parameter int AXIS_TDATA_WIDTH = 32,
  parameter int MAX_WIDTH        = 64,
  parameter int HOLDOFF_WIDTH    = 16
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          enable,
  input  logic signed [ADC_WIDTH-1:0]   adc_filt_a,
  input  logic signed [ADC_WIDTH-1:0]   threshold,
  input  logic [HOLDOFF_WIDTH-1:0]      holdoff,
  output logic [AXIS_TDATA_WIDTH-1:0]   m_axis_tdata,
  output logic                          m_axis_tvalid,
  input  logic                          m_axis_tready,
  output logic [15:0]                   drop_cnt,
  output logic [15:0]                   pileup_cnt
);
  localparam int TS_W = AXIS_TDATA_WIDTH - ADC_WIDTH;
  localparam int WW   = $clog2(MAX_WIDTH + 1);
  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] ACTIVE  = 2'd1;
  localparam logic [1:0] HOLDOFF = 2'd2;

  logic [1:0]                  state, state_nx, end_state;
  logic [TS_W-1:0]             ts_cnt, ts_cap;
  logic signed [ADC_WIDTH-1:0] peak;
  logic [WW-1:0]               width;
  logic [HOLDOFF_WIDTH-1:0]    hcnt;
  logic                        above, at_max, fall, pile, start, grow, load;

  assign above     = adc_filt_a > threshold;
  assign at_max    = width == WW'(MAX_WIDTH);
  assign start     = state == IDLE && enable && above;
  assign grow      = state == ACTIVE && enable && above && !at_max;
  assign fall      = state == ACTIVE && enable && !above;
  assign pile      = state == ACTIVE && enable && above && at_max;
  assign load      = fall && (!m_axis_tvalid || m_axis_tready);
  assign end_state = holdoff == '0 ? IDLE : HOLDOFF;

  always_comb begin
    state_nx = state;
    if (!enable)
      state_nx = IDLE;
    else
      case (state)
        IDLE:    state_nx = above ? ACTIVE : IDLE;
        ACTIVE:  state_nx = (fall || pile) ? end_state : ACTIVE;
        HOLDOFF: state_nx = hcnt == HOLDOFF_WIDTH'(1) ? IDLE : HOLDOFF;
        default: state_nx = IDLE;
      endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= IDLE;
      ts_cnt <= '0;
      ts_cap <= '0;
      peak   <= '0;
      width  <= '0;
      hcnt   <= '0;
    end else begin
      state  <= state_nx;
      ts_cnt <= ts_cnt + TS_W'(1);
      if (start) begin
        peak   <= adc_filt_a;
        ts_cap <= ts_cnt;
        width  <= WW'(1);
      end else if (grow) begin
        width <= width + WW'(1);
        if (adc_filt_a > peak) peak <= adc_filt_a;
      end
      if (fall || pile)
        hcnt <= holdoff;
      else if (state == HOLDOFF)
        hcnt <= hcnt - HOLDOFF_WIDTH'(1);
    end
  end

  // A new word wins over a concurrent handshake; a blocked word is dropped, not queued.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_axis_tdata  <= '0;
      m_axis_tvalid <= 1'b0;
      drop_cnt      <= '0;
      pileup_cnt    <= '0;
    end else begin
      if (load) begin
        m_axis_tdata  <= {ts_cap, peak};
        m_axis_tvalid <= 1'b1;
      end else if (m_axis_tready) begin
        m_axis_tvalid <= 1'b0;
      end
      if (fall && !load && drop_cnt != 16'hFFFF) drop_cnt <= drop_cnt + 16'd1;
      if (pile && pileup_cnt != 16'hFFFF) pileup_cnt <= pileup_cnt + 16'd1;
    end
  end
endmodule

// File: tb/tb_pulse_peak_detector.sv
// tb_pulse_peak_detector: directed and randomized checks against a queue-based pulse model.
module tb_pulse_peak_detector;
  localparam int AW = 14, DW = 32, MW = 64, HW = 16, TW = 18;

  logic clk = 0, reset = 0, enable = 0, m_axis_tready = 0;
  logic signed [AW-1:0] adc_filt_a = 0, threshold = 0;
  logic [HW-1:0] holdoff = 0;
  logic [DW-1:0] m_axis_tdata;
  logic m_axis_tvalid;
  logic [15:0] drop_cnt, pileup_cnt;
  int errors = 0, checks = 0;

  int m_ts, m_cap, m_dead, m_drop, m_pile;
  bit m_inp, m_vld;
  logic [31:0] m_data;
  int pulse[$];

  pulse_peak_detector #(.ADC_WIDTH(AW), .AXIS_TDATA_WIDTH(DW), .MAX_WIDTH(MW), .HOLDOFF_WIDTH(HW)) dut (
    .clk(clk), .reset(reset), .enable(enable), .adc_filt_a(adc_filt_a), .threshold(threshold),
    .holdoff(holdoff), .m_axis_tdata(m_axis_tdata), .m_axis_tvalid(m_axis_tvalid),
    .m_axis_tready(m_axis_tready), .drop_cnt(drop_cnt), .pileup_cnt(pileup_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset;
    m_ts = 0; m_cap = 0; m_dead = 0; m_drop = 0; m_pile = 0;
    m_inp = 0; m_vld = 0; m_data = 0;
    pulse.delete();
  endtask

  // One sample edge: a pulse is the list of its above-threshold samples; dead time is a countdown.
  task automatic model_edge;
    int s, thr, pk;
    bit emit;
    s = adc_filt_a; thr = threshold; emit = 0;
    if (!enable) begin
      m_inp = 0; m_dead = 0; pulse.delete();
    end else if (m_dead > 0) begin
      m_dead--;
    end else if (!m_inp) begin
      if (s > thr) begin m_inp = 1; pulse = {s}; m_cap = m_ts; end
    end else if (s > thr) begin
      if (pulse.size() == MW) begin
        if (m_pile < 65535) m_pile++;
        m_inp = 0; m_dead = holdoff; pulse.delete();
      end else pulse.push_back(s);
    end else begin
      emit = 1; m_inp = 0; m_dead = holdoff;
    end
    if (emit) begin
      pk = pulse[0];
      foreach (pulse[i]) if (pulse[i] > pk) pk = pulse[i];
      pulse.delete();
      if (!m_vld || m_axis_tready) begin
        m_vld = 1; m_data = {m_cap[TW-1:0], pk[AW-1:0]};
      end else if (m_drop < 65535) m_drop++;
    end else if (m_axis_tready) m_vld = 0;
    m_ts = (m_ts + 1) % (1 << TW);
  endtask

  task automatic step(input int s);
    adc_filt_a = AW'(s);
    @(posedge clk);
    model_edge();
    #1;
    check("tvalid", {31'd0, m_axis_tvalid}, {31'd0, m_vld});
    check("tdata", m_axis_tdata, m_data);
    check("drop_cnt", {16'd0, drop_cnt}, m_drop);
    check("pileup_cnt", {16'd0, pileup_cnt}, m_pile);
  endtask

  task automatic zeros(input int n);
    repeat (n) step(0);
  endtask

  initial begin
    int thr, lvl, len;
    bit hi;
    repeat (3) @(posedge clk);
    #1;
    check("rst_tvalid", {31'd0, m_axis_tvalid}, 0);
    check("rst_tdata", m_axis_tdata, 0);
    check("rst_drop", {16'd0, drop_cnt}, 0);
    check("rst_pile", {16'd0, pileup_cnt}, 0);
    model_reset();
    reset = 1; enable = 1; threshold = 100; holdoff = 4; m_axis_tready = 1;

    zeros(10);
    step(150); step(300); step(220);
    check("t1_not_yet", {31'd0, m_axis_tvalid}, 0);
    step(50);
    check("t1_valid", {31'd0, m_axis_tvalid}, 1);
    check("t1_word", m_axis_tdata, {18'd10, 14'd300});
    step(0);
    threshold = -50;
    repeat (7) step(-100);
    step(-20); step(-60);
    check("t2_valid", {31'd0, m_axis_tvalid}, 1);
    check("t2_peak", {18'd0, m_axis_tdata[13:0]}, {18'd0, 14'h3FEC});

    step(-100);
    threshold = 100;
    zeros(6);
    repeat (64) step(500);
    check("t3_pre_pile", {16'd0, pileup_cnt}, 0);
    step(500);
    check("t3_pile", {16'd0, pileup_cnt}, 1);
    check("t3_no_word", {31'd0, m_axis_tvalid}, 0);
    zeros(8);

    m_axis_tready = 0;
    step(200); step(0); zeros(6);
    step(300); step(0); zeros(6);
    step(400); step(0); zeros(6);
    check("t4_held_valid", {31'd0, m_axis_tvalid}, 1);
    check("t4_held_peak", {18'd0, m_axis_tdata[13:0]}, 200);
    check("t4_drops", {16'd0, drop_cnt}, 2);
    m_axis_tready = 1;
    step(0);
    check("t4_cleared", {31'd0, m_axis_tvalid}, 0);

    holdoff = 10;
    step(200); step(0); zeros(4);
    step(300); step(0); zeros(12);
    check("t5_ignored", {18'd0, m_axis_tdata[13:0]}, 200);
    step(200); step(0); zeros(10);
    step(300); step(0);
    check("t5_detected", {18'd0, m_axis_tdata[13:0]}, 300);
    zeros(12);

    holdoff = 4; m_axis_tready = 0;
    step(200); step(0); zeros(5);
    step(300); step(0); zeros(5);
    step(250);
    enable = 0; step(260);
    enable = 1; step(0); zeros(3);
    check("t6_en_drop", {16'd0, drop_cnt}, 3);
    check("t6_en_pile", {16'd0, pileup_cnt}, 1);
    check("t6_en_word", {18'd0, m_axis_tdata[13:0]}, 200);
    step(200);
    #3 reset = 0;
    #1;
    check("t6_rst_tvalid", {31'd0, m_axis_tvalid}, 0);
    check("t6_rst_tdata", m_axis_tdata, 0);
    check("t6_rst_drop", {16'd0, drop_cnt}, 0);
    check("t6_rst_pile", {16'd0, pileup_cnt}, 0);
    @(posedge clk);
    #1;
    model_reset();
    reset = 1;

    repeat (80) begin
      thr = int'($urandom_range(0, 2000)) - 1000;
      threshold = AW'(thr);
      holdoff = HW'($urandom_range(0, 6));
      hi = $urandom_range(0, 1) == 1;
      len = $urandom_range(1, 80);
      repeat (len) begin
        lvl = hi ? thr + int'($urandom_range(1, 400)) : thr - int'($urandom_range(0, 400));
        enable = $urandom_range(0, 49) != 0;
        m_axis_tready = $urandom_range(0, 9) < 7;
        step(lvl);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
